// File: rtl/cu_vertex_cache_read_arbiter.sv
// Round-robin, credit-limited read-command arbiter feeding the vertex cache-reuse datapath.
// Optional per-requester grant and stall statistics are enabled by defining CU_READ_ARB_STATS_EN.
module cu_vertex_cache_read_arbiter #(
   parameter int NUM_READ_REQUESTS = 4,
   parameter int CMD_W             = 64,
   parameter int MAX_OUTSTANDING   = 16,
   parameter int ID_W              = 2
) (
   input  logic                               clock,
   input  logic                               rst_in,
   input  logic                               enabled_in,
   input  logic [NUM_READ_REQUESTS-1:0]       req_valid,
   input  logic [NUM_READ_REQUESTS*CMD_W-1:0] req_cmd,
   output logic [NUM_READ_REQUESTS-1:0]       req_ready,
   output logic                               cmd_out_valid,
   output logic [CMD_W-1:0]                   cmd_out_payload,
   output logic [ID_W-1:0]                    cmd_out_id,
   input  logic                               cmd_buffer_full,
   input  logic                               resp_valid,
   output logic [7:0]                         outstanding,
   output logic                               idle_out
`ifdef CU_READ_ARB_STATS_EN
   ,
   output logic [NUM_READ_REQUESTS*32-1:0]    grant_count,
   output logic [31:0]                        stall_cycles
`endif
);

   localparam int N = NUM_READ_REQUESTS;
   localparam logic [7:0] MAX_CNT = 8'(MAX_OUTSTANDING);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ARB   = 2'd1,
      S_STALL = 2'd2,
      S_DRAIN = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [ID_W-1:0]   ptr_q, ptr_d;
   logic [7:0]        outstanding_q, outstanding_d;
   logic              cmd_out_valid_q, cmd_out_valid_d;
   logic [CMD_W-1:0]  cmd_out_payload_q, cmd_out_payload_d;
   logic [ID_W-1:0]   cmd_out_id_q, cmd_out_id_d;

   logic [CMD_W-1:0]  cmd_arr [N];
   logic [ID_W-1:0]   winner;
   logic [ID_W-1:0]   cand;
   logic              found;
   logic              stall_cond;
   logic              grant_en;
   logic              resp_take;

   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_unpack
         assign cmd_arr[gi] = req_cmd[gi*CMD_W +: CMD_W];
      end
   endgenerate

   // Credit check deliberately uses the registered count, so the grant at MAX-1 is allowed.
   assign stall_cond = cmd_buffer_full || (outstanding_q == MAX_CNT);
   assign grant_en   = (state_q == S_ARB) && enabled_in && !stall_cond && (|req_valid);
   assign resp_take  = resp_valid && (outstanding_q != 8'd0);

   always_comb begin
      found  = 1'b0;
      winner = ptr_q;
      cand   = ptr_q;
      for (int k = 0; k < N; k++) begin
         cand = ptr_q + ID_W'(k);
         if (!found && req_valid[cand]) begin
            found  = 1'b1;
            winner = cand;
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if (grant_en) begin
         req_ready[winner] = 1'b1;
      end
   end

   always_comb begin
      state_d           = state_q;
      ptr_d             = ptr_q;
      outstanding_d     = outstanding_q + 8'(grant_en) - 8'(resp_take);
      cmd_out_valid_d   = grant_en;
      cmd_out_payload_d = cmd_out_payload_q;
      cmd_out_id_d      = cmd_out_id_q;
      if (grant_en) begin
         ptr_d             = winner + 1'b1;
         cmd_out_payload_d = cmd_arr[winner];
         cmd_out_id_d      = winner;
      end
      case (state_q)
         S_IDLE: begin
            if (enabled_in) state_d = S_ARB;
         end
         S_ARB: begin
            if (!enabled_in)     state_d = S_DRAIN;
            else if (stall_cond) state_d = S_STALL;
         end
         S_STALL: begin
            if (!enabled_in)                                      state_d = S_DRAIN;
            else if (!cmd_buffer_full && outstanding_q < MAX_CNT) state_d = S_ARB;
         end
         // Leave as soon as the last response lands so idle_out rises the following cycle.
         S_DRAIN: begin
            if (outstanding_d == 8'd0) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (rst_in) begin
         state_q           <= S_IDLE;
         ptr_q             <= '0;
         outstanding_q     <= '0;
         cmd_out_valid_q   <= 1'b0;
         cmd_out_payload_q <= '0;
         cmd_out_id_q      <= '0;
      end else begin
         state_q           <= state_d;
         ptr_q             <= ptr_d;
         outstanding_q     <= outstanding_d;
         cmd_out_valid_q   <= cmd_out_valid_d;
         cmd_out_payload_q <= cmd_out_payload_d;
         cmd_out_id_q      <= cmd_out_id_d;
      end
   end

   assign cmd_out_valid   = cmd_out_valid_q;
   assign cmd_out_payload = cmd_out_payload_q;
   assign cmd_out_id      = cmd_out_id_q;
   assign outstanding     = outstanding_q;
   assign idle_out        = (state_q == S_IDLE) && (outstanding_q == 8'd0);

`ifdef CU_READ_ARB_STATS_EN
   logic [31:0] stall_cycles_q, stall_cycles_d;

   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_grant_cnt
         logic [31:0] cnt_q, cnt_d;
         always_comb begin
            cnt_d = cnt_q;
            if (req_ready[gi] && cnt_q != 32'hFFFF_FFFF) cnt_d = cnt_q + 32'd1;
         end
         always_ff @(posedge clock) begin
            if (rst_in) cnt_q <= '0;
            else        cnt_q <= cnt_d;
         end
         assign grant_count[gi*32 +: 32] = cnt_q;
      end
   endgenerate

   always_comb begin
      stall_cycles_d = stall_cycles_q;
      if (state_q == S_STALL && stall_cycles_q != 32'hFFFF_FFFF) stall_cycles_d = stall_cycles_q + 32'd1;
   end

   always_ff @(posedge clock) begin
      if (rst_in) stall_cycles_q <= '0;
      else        stall_cycles_q <= stall_cycles_d;
   end

   assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_cu_vertex_cache_read_arbiter.sv
// Directed bench for cu_vertex_cache_read_arbiter with a 4-credit limit and hand-computed expectations.
module tb_cu_vertex_cache_read_arbiter;

   localparam int N     = 4;
   localparam int CMD_W = 64;
   localparam int ID_W  = 2;

   logic             clock = 1'b0;
   logic             rst_in;
   logic             enabled_in;
   logic [N-1:0]     req_valid;
   logic [N*CMD_W-1:0] req_cmd;
   logic [N-1:0]     req_ready;
   logic             cmd_out_valid;
   logic [CMD_W-1:0] cmd_out_payload;
   logic [ID_W-1:0]  cmd_out_id;
   logic             cmd_buffer_full;
   logic             resp_valid;
   logic [7:0]       outstanding;
   logic             idle_out;
`ifdef CU_READ_ARB_STATS_EN
   logic [N*32-1:0]  grant_count;
   logic [31:0]      stall_cycles;
`endif

   int checks   = 0;
   int failures = 0;

   cu_vertex_cache_read_arbiter #(
      .NUM_READ_REQUESTS(N),
      .CMD_W(CMD_W),
      .MAX_OUTSTANDING(4),
      .ID_W(ID_W)
   ) dut (
      .clock(clock),
      .rst_in(rst_in),
      .enabled_in(enabled_in),
      .req_valid(req_valid),
      .req_cmd(req_cmd),
      .req_ready(req_ready),
      .cmd_out_valid(cmd_out_valid),
      .cmd_out_payload(cmd_out_payload),
      .cmd_out_id(cmd_out_id),
      .cmd_buffer_full(cmd_buffer_full),
      .resp_valid(resp_valid),
      .outstanding(outstanding),
      .idle_out(idle_out)
`ifdef CU_READ_ARB_STATS_EN
      ,
      .grant_count(grant_count),
      .stall_cycles(stall_cycles)
`endif
   );

   always #5 clock = ~clock;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end else begin
         $display("ok   %s = %h", tag, got);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   function automatic logic [63:0] pay(input int i);
      return {32'hC0DE_0000 + 32'(i), 32'h1234_5670 + 32'(i * 3)};
   endfunction

   function automatic logic [N-1:0] onehot(input int i);
      logic [N-1:0] v;
      v = '0;
      v[i % N] = 1'b1;
      return v;
   endfunction

   initial begin
      logic [N-1:0] last_rdy;
      int           cnt;
      bit           seen;

      rst_in = 1'b1; enabled_in = 1'b0; req_valid = '0; cmd_buffer_full = 1'b0; resp_valid = 1'b0;
      for (int i = 0; i < N; i++) req_cmd[i*CMD_W +: CMD_W] = pay(i);
      step(); step();
      rst_in = 1'b0;
      #1;
      check_val("rst_valid", 64'(cmd_out_valid), 64'd0);
      check_val("rst_payload", 64'(cmd_out_payload), 64'd0);
      check_val("rst_id", 64'(cmd_out_id), 64'd0);
      check_val("rst_outstanding", 64'(outstanding), 64'd0);
      check_val("rst_idle", 64'(idle_out), 64'd1);
      check_val("rst_ready", 64'(req_ready), 64'd0);

      // Fairness: all valid, response every cycle.
      enabled_in = 1'b1; req_valid = 4'hF; resp_valid = 1'b1;
      #1;
      check_val("idle_no_grant", 64'(req_ready), 64'd0);
      step();
      for (int k = 0; k < 6; k++) begin
         #1;
         check_val($sformatf("rr_ready_%0d", k), 64'(req_ready), 64'(onehot(k)));
         step();
         check_val($sformatf("rr_valid_%0d", k), 64'(cmd_out_valid), 64'd1);
         check_val($sformatf("rr_id_%0d", k), 64'(cmd_out_id), 64'(k % N));
         check_val($sformatf("rr_payload_%0d", k), cmd_out_payload, pay(k % N));
      end
      check_val("rr_outstanding", 64'(outstanding), 64'd1);
      req_valid = '0;
      step();
      check_val("rr_pulse_end", 64'(cmd_out_valid), 64'd0);
      check_val("resp_to_zero", 64'(outstanding), 64'd0);
      step();
      check_val("resp_at_zero", 64'(outstanding), 64'd0);

      // Credit limit: pointer now 2, no responses.
      resp_valid = 1'b0; req_valid = 4'hF;
      for (int k = 0; k < 4; k++) begin
         #1;
         check_val($sformatf("cred_ready_%0d", k), 64'(req_ready), 64'(onehot(2 + k)));
         step();
      end
      check_val("cred_full", 64'(outstanding), 64'd4);
      for (int k = 0; k < 2; k++) begin
         #1;
         check_val($sformatf("cred_stall_%0d", k), 64'(req_ready), 64'd0);
         step();
      end
      resp_valid = 1'b1;
      #1;
      check_val("cred_resp_no_grant", 64'(req_ready), 64'd0);
      step();
      resp_valid = 1'b0;
      cnt = 0; last_rdy = '0;
      for (int k = 0; k < 5; k++) begin
         #1;
         if (req_ready != '0) begin
            cnt++;
            last_rdy = req_ready;
         end
         step();
      end
      check_val("cred_one_more_cnt", 64'(cnt), 64'd1);
      check_val("cred_one_more_who", 64'(last_rdy), 64'(4'b0100));
      check_val("cred_full_again", 64'(outstanding), 64'd4);

      // Drain: bring to 3 outstanding, then disable with requests pending.
      req_valid = '0; resp_valid = 1'b1;
      step();
      check_val("drain_start", 64'(outstanding), 64'd3);
      enabled_in = 1'b0; req_valid = 4'hF;
      for (int k = 0; k < 3; k++) begin
         #1;
         check_val($sformatf("drain_ready_%0d", k), 64'(req_ready), 64'd0);
         step();
         check_val($sformatf("drain_cnt_%0d", k), 64'(outstanding), 64'(2 - k));
         check_val($sformatf("drain_idle_%0d", k), 64'(idle_out), (k == 2) ? 64'd1 : 64'd0);
      end
      resp_valid = 1'b0;

      // Backpressure: pointer now 3.
      enabled_in = 1'b1; cmd_buffer_full = 1'b1;
      step();
      for (int k = 0; k < 10; k++) begin
         #1;
         check_val($sformatf("bp_ready_%0d", k), 64'(req_ready), 64'd0);
         step();
      end
      cmd_buffer_full = 1'b0;
      seen = 1'b0; last_rdy = '0;
      for (int k = 0; k < 4 && !seen; k++) begin
         #1;
         if (req_ready != '0) begin
            seen = 1'b1;
            last_rdy = req_ready;
         end
         step();
      end
      check_val("bp_resume", 64'(last_rdy), 64'(4'b1000));
      check_val("bp_resume_id", 64'(cmd_out_id), 64'd3);
      #1;
      check_val("bp_next", 64'(req_ready), 64'(4'b0001));
      step();
      check_val("sim_pre", 64'(outstanding), 64'd2);

      // Acceptance and response in the same cycle.
      resp_valid = 1'b1;
      #1;
      check_val("sim_ready", 64'(req_ready), 64'(4'b0010));
      step();
      check_val("sim_hold", 64'(outstanding), 64'd2);
      resp_valid = 1'b0;
      #1;
      check_val("sim_next", 64'(req_ready), 64'(4'b0100));
      step();
      check_val("pre_rst_cnt", 64'(outstanding), 64'd3);

      // enabled_in falls while a grant would be pending.
      enabled_in = 1'b0;
      #1;
      check_val("en_drop_ready", 64'(req_ready), 64'd0);
      step();

      // Reset mid-traffic with reads outstanding.
      rst_in = 1'b1;
      step(); step(); step();
      rst_in = 1'b0;
      #1;
      check_val("mid_rst_cnt", 64'(outstanding), 64'd0);
      check_val("mid_rst_valid", 64'(cmd_out_valid), 64'd0);
      check_val("mid_rst_idle", 64'(idle_out), 64'd1);
      enabled_in = 1'b1;
      step();
      #1;
      check_val("mid_rst_ptr", 64'(req_ready), 64'(4'b0001));
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule
